// File: rtl/dcnn_pkg.sv
// Shared definitions for the DCNN core: default widths, lane data types and
// the shift-and-saturate helper used by every quantizing stage.
package dcnn_pkg;

  localparam int DCNN_DW               = 32;
  localparam int DCNN_OW               = 16;
  localparam int DCNN_MAX_PARA_OUT     = 64;
  localparam int DCNN_MAX_PARA_OUT_BIT = 7;
  localparam int DCNN_SHIFT_BITS       = 5;

  typedef logic signed [DCNN_DW-1:0] psum_t;
  typedef logic signed [DCNN_OW-1:0] feat_t;

  // Arithmetic right shift followed by clamping into a signed outWidth-bit range.
  // Works on a 64-bit container so callers of any width up to 63 bits can share it.
  function automatic logic signed [63:0] sat_shift(input logic signed [63:0] value,
                                                   input int shift,
                                                   input int outWidth);
    logic signed [63:0] shifted;
    logic signed [63:0] hiLim;
    logic signed [63:0] loLim;
    shifted = value >>> shift;
    hiLim   = (64'sd1 <<< (outWidth - 1)) - 64'sd1;
    loLim   = -(64'sd1 <<< (outWidth - 1));
    if (shifted > hiLim) begin
      return hiLim;
    end
    if (shifted < loLim) begin
      return loLim;
    end
    return shifted;
  endfunction

endpackage

// File: rtl/dcnn_s2_psum_drain_if.sv
// Output feature stream of the s2 drain stage towards the feature-map writer.
interface dcnn_s2_psum_drain_if #(
  parameter int OW = 16
) ();

  logic signed [OW-1:0] feat_out;
  logic                 feat_out_vld;
  logic                 feat_out_last;
  logic                 feat_out_rdy;

  modport master (
    output feat_out,
    output feat_out_vld,
    output feat_out_last,
    input  feat_out_rdy
  );

  modport slave (
    input  feat_out,
    input  feat_out_vld,
    input  feat_out_last,
    output feat_out_rdy
  );

endinterface

// File: rtl/dcnn_s2_post.sv
// Per-lane post-processing on the drain path: bias add, optional ReLU,
// arithmetic shift and saturation to the output feature width.
module dcnn_s2_post
  import dcnn_pkg::*;
#(
  parameter int DW         = DCNN_DW,
  parameter int OW         = DCNN_OW,
  parameter int SHIFT_BITS = DCNN_SHIFT_BITS
) (
  input  logic signed [DW-1:0]   psum_i,
  input  logic signed [DW-1:0]   bias_i,
  input  logic                   relu_en_i,
  input  logic [SHIFT_BITS-1:0]  frac_shift_i,
  output logic signed [OW-1:0]   feat_o
);

  logic signed [DW:0] biasedSum;

  // One extra bit on the sum so psum + bias can never wrap before saturation.
  always_comb begin
    biasedSum = (DW+1)'(psum_i) + (DW+1)'(bias_i);
    if (relu_en_i && biasedSum[DW]) begin
      biasedSum = '0;
    end
    feat_o = OW'(sat_shift(64'(biasedSum), int'(frac_shift_i), OW));
  end

endmodule

// File: rtl/dcnn_s2_psum_drain.sv
// Stage s2 of the DCNN core: gathers one group of lane partial sums into a
// two-bank ping-pong buffer and serializes the post-processed lanes onto a
// single valid/ready feature stream.
module dcnn_s2_psum_drain
  import dcnn_pkg::*;
#(
  parameter int DW               = DCNN_DW,
  parameter int OW               = DCNN_OW,
  parameter int MAX_PARA_OUT     = DCNN_MAX_PARA_OUT,
  parameter int MAX_PARA_OUT_BIT = DCNN_MAX_PARA_OUT_BIT,
  parameter int SHIFT_BITS       = DCNN_SHIFT_BITS
) (
  input  logic                         clk,
  input  logic                         arst_n,
  input  logic                         clear,
  input  logic [MAX_PARA_OUT_BIT-1:0]  para_out_num,
  input  logic                         relu_en,
  input  logic [SHIFT_BITS-1:0]        frac_shift,
  input  logic signed [DW-1:0]         bias_in          [0:MAX_PARA_OUT-1],
  input  logic signed [DW-1:0]         psum_para_in     [0:MAX_PARA_OUT-1],
  input  logic                         psum_para_in_vld [0:MAX_PARA_OUT-1],
  dcnn_s2_psum_drain_if.master         out_if,
  output logic                         idle,
  output logic                         overrun_err
);

  localparam int LW   = MAX_PARA_OUT_BIT;
  localparam int LIDX = $clog2(MAX_PARA_OUT);

  // Capture side state
  logic [MAX_PARA_OUT-1:0] capturedMask_q, capturedMask_d;
  logic [LW-1:0]           nGrp_q, nGrp_d;
  logic                    wrBank_q, wrBank_d;
  logic [1:0]              bankFull_q, bankFull_d;
  logic [LW-1:0]           bankN_q [2];
  logic [LW-1:0]           bankN_d [2];
  logic signed [DW-1:0]    bankData_q [2][MAX_PARA_OUT];

  // Drain side state
  logic                    rdBank_q, rdBank_d;
  logic                    drainBank_q, drainBank_d;
  logic [LW-1:0]           laneIdx_q, laneIdx_d;
  logic signed [OW-1:0]    featData_q, featData_d;
  logic                    featVld_q, featVld_d;
  logic                    featLast_q, featLast_d;
  logic                    overrun_q, overrun_d;

  // Combinational helpers
  logic [LW-1:0]           nClamp, nEff;
  logic [MAX_PARA_OUT-1:0] laneMask, acceptLane, capturedNext;
  logic                    dropHit, groupDone;
  logic                    outAccept, freeBank, loadBeat, lastLane;
  logic signed [DW-1:0]    postPsum, postBias;
  logic signed [OW-1:0]    postFeat;

  // Lane count in force: the live input until the group's first capture, the latched copy afterwards.
  assign nClamp = (int'(para_out_num) > MAX_PARA_OUT) ? LW'(MAX_PARA_OUT) : para_out_num;
  assign nEff   = (capturedMask_q == '0) ? nClamp : nGrp_q;

  // Decide per lane whether an arriving valid is stored, ignored or dropped as an overrun.
  always_comb begin
    laneMask   = '0;
    acceptLane = '0;
    dropHit    = 1'b0;
    for (int i = 0; i < MAX_PARA_OUT; i++) begin
      laneMask[i] = (i < int'(nEff));
      if (psum_para_in_vld[i] && laneMask[i]) begin
        if (bankFull_q[wrBank_q] || capturedMask_q[i]) begin
          dropHit = 1'b1;
        end else begin
          acceptLane[i] = 1'b1;
        end
      end
    end
    capturedNext = capturedMask_q | acceptLane;
    groupDone    = (acceptLane != '0) && ((capturedNext & laneMask) == laneMask);
  end

  // Drain pointer lookups; drainBank runs ahead of rdBank so the next group can load while the last beat waits.
  always_comb begin
    outAccept = featVld_q && out_if.feat_out_rdy;
    freeBank  = outAccept && featLast_q;
    loadBeat  = bankFull_q[drainBank_q] && (!featVld_q || out_if.feat_out_rdy);
    lastLane  = (laneIdx_q == (bankN_q[drainBank_q] - LW'(1)));
    postPsum  = bankData_q[drainBank_q][laneIdx_q[LIDX-1:0]];
    postBias  = bias_in[laneIdx_q[LIDX-1:0]];
  end

  dcnn_s2_post #(
    .DW         (DW),
    .OW         (OW),
    .SHIFT_BITS (SHIFT_BITS)
  ) u_post (
    .psum_i       (postPsum),
    .bias_i       (postBias),
    .relu_en_i    (relu_en),
    .frac_shift_i (frac_shift),
    .feat_o       (postFeat)
  );

  // Next-state for capture, bank bookkeeping and the output register; clear overrides everything.
  always_comb begin
    capturedMask_d = groupDone ? '0 : capturedNext;
    nGrp_d         = nGrp_q;
    if ((capturedMask_q == '0) && (acceptLane != '0)) begin
      nGrp_d = nClamp;
    end

    bankFull_d = bankFull_q;
    bankN_d    = bankN_q;
    wrBank_d   = wrBank_q;
    rdBank_d   = rdBank_q;
    if (groupDone) begin
      bankFull_d[wrBank_q] = 1'b1;
      bankN_d[wrBank_q]    = nEff;
      wrBank_d             = ~wrBank_q;
    end
    if (freeBank) begin
      bankFull_d[rdBank_q] = 1'b0;
      rdBank_d             = ~rdBank_q;
    end

    featData_d  = featData_q;
    featVld_d   = featVld_q;
    featLast_d  = featLast_q;
    laneIdx_d   = laneIdx_q;
    drainBank_d = drainBank_q;
    if (outAccept) begin
      featVld_d  = 1'b0;
      featLast_d = 1'b0;
    end
    if (loadBeat) begin
      featData_d = postFeat;
      featVld_d  = 1'b1;
      featLast_d = lastLane;
      if (lastLane) begin
        laneIdx_d   = '0;
        drainBank_d = ~drainBank_q;
      end else begin
        laneIdx_d = laneIdx_q + LW'(1);
      end
    end

    overrun_d = overrun_q | dropHit;

    if (clear) begin
      capturedMask_d = '0;
      nGrp_d         = '0;
      bankFull_d     = '0;
      bankN_d[0]     = '0;
      bankN_d[1]     = '0;
      wrBank_d       = 1'b0;
      rdBank_d       = 1'b0;
      drainBank_d    = 1'b0;
      laneIdx_d      = '0;
      featData_d     = '0;
      featVld_d      = 1'b0;
      featLast_d     = 1'b0;
      overrun_d      = 1'b0;
    end
  end

  // Control state register with asynchronous reset.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      capturedMask_q <= '0;
      nGrp_q         <= '0;
      bankFull_q     <= '0;
      bankN_q[0]     <= '0;
      bankN_q[1]     <= '0;
      wrBank_q       <= 1'b0;
      rdBank_q       <= 1'b0;
      drainBank_q    <= 1'b0;
      laneIdx_q      <= '0;
      featData_q     <= '0;
      featVld_q      <= 1'b0;
      featLast_q     <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      capturedMask_q <= capturedMask_d;
      nGrp_q         <= nGrp_d;
      bankFull_q     <= bankFull_d;
      bankN_q        <= bankN_d;
      wrBank_q       <= wrBank_d;
      rdBank_q       <= rdBank_d;
      drainBank_q    <= drainBank_d;
      laneIdx_q      <= laneIdx_d;
      featData_q     <= featData_d;
      featVld_q      <= featVld_d;
      featLast_q     <= featLast_d;
      overrun_q      <= overrun_d;
    end
  end

  // Bank payload storage; validity lives in the full flags so the data needs no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < MAX_PARA_OUT; i++) begin
      if (!clear && acceptLane[i]) begin
        bankData_q[wrBank_q][i] <= psum_para_in[i];
      end
    end
  end

  assign out_if.feat_out      = featData_q;
  assign out_if.feat_out_vld  = featVld_q;
  assign out_if.feat_out_last = featLast_q;
  assign overrun_err          = overrun_q;
  assign idle = !bankFull_q[0] && !bankFull_q[1] && (capturedMask_q == '0) && !featVld_q;

endmodule

// File: tb/tb_dcnn_s2_psum_drain.sv
// Directed self-checking bench for the s2 partial-sum drain stage.
module tb_dcnn_s2_psum_drain;
  import dcnn_pkg::*;

  localparam int NL = DCNN_MAX_PARA_OUT;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        clear;
  logic [6:0]  paraOutNum;
  logic        reluEn;
  logic [4:0]  fracShift;
  psum_t       biasIn [0:NL-1];
  psum_t       psumIn [0:NL-1];
  logic        vldIn  [0:NL-1];
  logic        idle;
  logic        overrunErr;

  int checkCount = 0;
  int errorCount = 0;
  int cycleCnt   = 0;
  int stimCyc    = 0;

  feat_t obsData[$];
  logic  obsLast[$];
  int    obsCyc[$];

  dcnn_s2_psum_drain_if #(.OW(DCNN_OW)) dutIf ();

  dcnn_s2_psum_drain dut (
    .clk              (clk),
    .arst_n           (arst_n),
    .clear            (clear),
    .para_out_num     (paraOutNum),
    .relu_en          (reluEn),
    .frac_shift       (fracShift),
    .bias_in          (biasIn),
    .psum_para_in     (psumIn),
    .psum_para_in_vld (vldIn),
    .out_if           (dutIf.master),
    .idle             (idle),
    .overrun_err      (overrunErr)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Cycle counter used for latency and gap measurements
  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  // Record every accepted beat in the middle of the cycle
  always @(negedge clk) begin
    if (arst_n && dutIf.feat_out_vld && dutIf.feat_out_rdy) begin
      obsData.push_back(dutIf.feat_out);
      obsLast.push_back(dutIf.feat_out_last);
      obsCyc.push_back(cycleCnt);
    end
  end

  // Hard stop if something never completes
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: run did not complete, observed time limit, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic signed [63:0] observed,
                             input logic signed [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Pulse lanes firstLane..firstLane+count-1 for one cycle with values baseValue+k
  task automatic applyStimulus(input int firstLane, input int count, input int baseValue);
    for (int k = 0; k < count; k++) begin
      psumIn[firstLane+k] = psum_t'(baseValue + k);
      vldIn[firstLane+k]  = 1'b1;
    end
    stimCyc = cycleCnt;
    tick(1);
    for (int k = 0; k < count; k++) vldIn[firstLane+k] = 1'b0;
  endtask

  task automatic waitBeats(input string tag, input int count, input int maxCycles);
    int spent = 0;
    while (obsData.size() < count && spent < maxCycles) begin
      tick(1);
      spent++;
    end
    checkOutput(tag, obsData.size(), count);
  endtask

  task automatic waitIdle(input string tag, input int maxCycles);
    int spent = 0;
    while (!idle && spent < maxCycles) begin
      tick(1);
      spent++;
    end
    checkOutput(tag, idle, 1);
  endtask

  task automatic clearObs();
    obsData.delete();
    obsLast.delete();
    obsCyc.delete();
  endtask

  function automatic logic signed [63:0] getData(input int j);
    if (j < obsData.size()) return 64'(obsData[j]);
    return 'x;
  endfunction

  function automatic int getCyc(input int j);
    if (j < obsCyc.size()) return obsCyc[j];
    return -1000;
  endfunction

  function automatic logic [15:0] lastPattern(input int count);
    logic [15:0] lp = '0;
    for (int j = 0; j < count; j++) begin
      if (j < obsLast.size() && obsLast[j] === 1'b1) lp[j] = 1'b1;
    end
    return lp;
  endfunction

  initial begin
    int lane3Cyc;
    int exp1 [4] = '{1, -2, 3, 32767};

    arst_n     = 1'b0;
    clear      = 1'b0;
    paraOutNum = 7'd4;
    reluEn     = 1'b0;
    fracShift  = 5'd0;
    for (int i = 0; i < NL; i++) begin
      biasIn[i] = '0;
      psumIn[i] = '0;
      vldIn[i]  = 1'b0;
    end
    dutIf.feat_out_rdy = 1'b1;

    // Reset state
    #23;
    checkOutput("rst vld", dutIf.feat_out_vld, 0);
    checkOutput("rst last", dutIf.feat_out_last, 0);
    checkOutput("rst data", dutIf.feat_out, 0);
    checkOutput("rst idle", idle, 1);
    checkOutput("rst overrun", overrunErr, 0);
    #4 arst_n = 1'b1;
    tick(2);

    // Test 1: staggered lanes, saturation, latency
    clearObs();
    applyStimulus(0, 1, 1);
    applyStimulus(1, 1, -2);
    applyStimulus(2, 1, 3);
    applyStimulus(3, 1, 70000);
    lane3Cyc = stimCyc;
    waitBeats("t1 beats", 4, 20);
    for (int j = 0; j < 4; j++) checkOutput($sformatf("t1 data%0d", j), getData(j), exp1[j]);
    checkOutput("t1 last pattern", lastPattern(4), 16'b1000);
    checkOutput("t1 latency", getCyc(0) - lane3Cyc, 2);
    waitIdle("t1 idle", 20);

    // Test 2: bias, ReLU and shift
    paraOutNum = 7'd2;
    reluEn     = 1'b1;
    fracShift  = 5'd2;
    biasIn[0]  = -10;
    biasIn[1]  = 5;
    clearObs();
    applyStimulus(0, 1, 4);
    applyStimulus(1, 1, 40);
    waitBeats("t2 beats", 2, 20);
    checkOutput("t2 data0", getData(0), 0);
    checkOutput("t2 data1", getData(1), 11);
    checkOutput("t2 last pattern", lastPattern(2), 16'b10);
    waitIdle("t2 idle", 20);

    // Test 3: three back-to-back groups, no bubble
    reluEn     = 1'b0;
    fracShift  = 5'd0;
    biasIn[0]  = '0;
    biasIn[1]  = '0;
    paraOutNum = 7'd3;
    clearObs();
    applyStimulus(0, 3, 100);
    applyStimulus(0, 3, 200);
    tick(3);
    applyStimulus(0, 3, 300);
    waitBeats("t3 beats", 9, 40);
    for (int j = 0; j < 9; j++) checkOutput($sformatf("t3 data%0d", j), getData(j), 100 * (j / 3 + 1) + j % 3);
    checkOutput("t3 last pattern", lastPattern(9), 16'b100100100);
    checkOutput("t3 span", getCyc(8) - getCyc(0), 8);
    checkOutput("t3 overrun", overrunErr, 0);
    waitIdle("t3 idle", 20);

    // Test 4: stalled output, third group dropped
    paraOutNum = 7'd2;
    dutIf.feat_out_rdy = 1'b0;
    clearObs();
    applyStimulus(0, 2, 11);
    applyStimulus(0, 2, 21);
    applyStimulus(0, 2, 31);
    tick(3);
    checkOutput("t4 overrun", overrunErr, 1);
    checkOutput("t4 hold vld", dutIf.feat_out_vld, 1);
    checkOutput("t4 hold data", dutIf.feat_out, 11);
    checkOutput("t4 hold last", dutIf.feat_out_last, 0);
    checkOutput("t4 stalled beats", obsData.size(), 0);
    dutIf.feat_out_rdy = 1'b1;
    waitBeats("t4 beats", 4, 20);
    checkOutput("t4 data0", getData(0), 11);
    checkOutput("t4 data1", getData(1), 12);
    checkOutput("t4 data2", getData(2), 21);
    checkOutput("t4 data3", getData(3), 22);
    checkOutput("t4 last pattern", lastPattern(4), 16'b1010);
    tick(3);
    checkOutput("t4 no extra beats", obsData.size(), 4);
    checkOutput("t4 idle", idle, 1);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    checkOutput("t4 overrun cleared", overrunErr, 0);

    // Test 5: duplicate lane and out-of-range lane
    clearObs();
    applyStimulus(0, 1, 7);
    applyStimulus(0, 1, 8);
    applyStimulus(1, 1, 9);
    waitBeats("t5 beats", 2, 20);
    checkOutput("t5 data0", getData(0), 7);
    checkOutput("t5 data1", getData(1), 9);
    checkOutput("t5 overrun", overrunErr, 1);
    waitIdle("t5 idle", 20);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    clearObs();
    applyStimulus(5, 1, 55);
    tick(2);
    checkOutput("t5 lane5 overrun", overrunErr, 0);
    checkOutput("t5 lane5 idle", idle, 1);
    applyStimulus(0, 2, 61);
    waitBeats("t5b beats", 2, 20);
    tick(2);
    checkOutput("t5b beat count", obsData.size(), 2);
    checkOutput("t5b data0", getData(0), 61);
    checkOutput("t5b data1", getData(1), 62);

    // Test 6: reset mid-drain, then a fresh group
    waitIdle("t6 start idle", 20);
    paraOutNum = 7'd4;
    clearObs();
    applyStimulus(0, 4, 1000);
    waitBeats("t6 first beat", 1, 20);
    #2 arst_n = 1'b0;
    #1;
    checkOutput("t6 rst vld", dutIf.feat_out_vld, 0);
    checkOutput("t6 rst last", dutIf.feat_out_last, 0);
    checkOutput("t6 rst data", dutIf.feat_out, 0);
    checkOutput("t6 rst idle", idle, 1);
    checkOutput("t6 rst overrun", overrunErr, 0);
    #3 arst_n = 1'b1;
    tick(2);
    checkOutput("t6 post idle", idle, 1);
    paraOutNum = 7'd2;
    clearObs();
    applyStimulus(0, 2, 5);
    waitBeats("t6 beats", 2, 20);
    tick(3);
    checkOutput("t6 beat count", obsData.size(), 2);
    checkOutput("t6 data0", getData(0), 5);
    checkOutput("t6 data1", getData(1), 6);
    checkOutput("t6 last pattern", lastPattern(2), 16'b10);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
